// File: rtl/ngc_timer_sched_pkg.sv
// Shared types and helpers for the timer scheduler and its round-robin arbiter.
package ngc_timer_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } sched_state_e;

  // Index of the k-th candidate when scanning from base with wrap at n (base < n, k < n).
  function automatic int unsigned rr_index(input int unsigned base,
                                           input int unsigned k,
                                           input int unsigned n);
    int unsigned s;
    s = base + k;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/ngc_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, wrapping.
module ngc_rr_arbiter
  import ngc_timer_sched_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           any
);

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[rr_index(32'(ptr), k, N)]) begin
        any                             = 1'b1;
        gnt[rr_index(32'(ptr), k, N)]   = 1'b1;
        gnt_id                          = IDW'(rr_index(32'(ptr), k, N));
      end
    end
  end

endmodule

// File: rtl/ngc_timer_sched.sv
// Time-shares one up-counting one-shot counter among N_REQ requesters.
// Handshake: req[i] is a level held until ack[i]; ack and done are single-cycle one-hot pulses.
module ngc_timer_sched
  import ngc_timer_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] delay,
  output logic [N_REQ-1:0]       ack,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic                   cnt_rst,
  output logic                   cnt_load,
  output logic                   cnt_enb,
  output logic                   cnt_dir,
  output logic                   cnt_one_shot,
  output logic [WIDTH-1:0]       cnt_count_from_value,
  output logic [WIDTH-1:0]       cnt_load_value,
  output logic [WIDTH-1:0]       cnt_step_value,
  output logic [WIDTH-1:0]       cnt_count_to_value,
  input  logic                   cnt_count_hit
);

  localparam int IDW = $clog2(N_REQ);

  sched_state_e     state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [N_REQ-1:0] owner_q, owner_d;
  logic [WIDTH-1:0] delay_q, delay_d;

  logic [N_REQ-1:0] arb_gnt;
  logic [IDW-1:0]   arb_id;
  logic             arb_any;

  ngc_rr_arbiter #(.N(N_REQ), .IDW(IDW)) u_arb (
    .req    (req),
    .ptr    (ptr_q),
    .gnt    (arb_gnt),
    .gnt_id (arb_id),
    .any    (arb_any)
  );

  assign cnt_rst              = rst;
  assign cnt_dir              = 1'b0;
  assign cnt_one_shot         = 1'b1;
  assign cnt_step_value       = WIDTH'(1);
  assign cnt_count_from_value = '0;
  assign cnt_load_value       = '0;
  assign cnt_count_to_value   = delay_q;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    owner_d  = owner_q;
    delay_d  = delay_q;
    ack      = '0;
    done     = '0;
    busy     = 1'b0;
    cnt_load = 1'b0;
    cnt_enb  = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d = LOAD;
          id_d    = arb_id;
          owner_d = arb_gnt;
          delay_d = delay[32'(arb_id)*WIDTH +: WIDTH];
        end
      end
      LOAD: begin
        busy     = 1'b1;
        ack      = owner_q;
        cnt_load = 1'b1;
        state_d  = RUN;
      end
      RUN: begin
        busy    = 1'b1;
        cnt_enb = 1'b1;
        if (cnt_count_hit) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = owner_q;
        state_d = IDLE;
        // Next search starts just after the owner so it cannot win twice in a row.
        ptr_d   = (id_q == IDW'(N_REQ - 1)) ? '0 : id_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Aborted timers are silent: nothing leaves the block while reset is held.
    if (rst) begin
      ack      = '0;
      done     = '0;
      busy     = 1'b0;
      cnt_load = 1'b0;
      cnt_enb  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      owner_q <= '0;
      delay_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      owner_q <= owner_d;
      delay_q <= delay_d;
    end
  end

endmodule

// File: tb/tb_ngc_timer_sched.sv
// Bench for ngc_timer_sched: event-level reference model feeding an expected queue, checked by a monitor.
module tb_ngc_timer_sched;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int EW = 1 + N + 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] delay;
  logic [N-1:0]   ack, done;
  logic           busy, cnt_rst, cnt_load, cnt_enb, cnt_dir, cnt_one_shot;
  logic [W-1:0]   cnt_count_from_value, cnt_load_value, cnt_step_value, cnt_count_to_value;
  logic           cnt_count_hit;

  always #5 clk = ~clk;

  ngc_timer_sched #(.N_REQ(N), .WIDTH(W)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .req                  (req),
    .delay                (delay),
    .ack                  (ack),
    .done                 (done),
    .busy                 (busy),
    .cnt_rst              (cnt_rst),
    .cnt_load             (cnt_load),
    .cnt_enb              (cnt_enb),
    .cnt_dir              (cnt_dir),
    .cnt_one_shot         (cnt_one_shot),
    .cnt_count_from_value (cnt_count_from_value),
    .cnt_load_value       (cnt_load_value),
    .cnt_step_value       (cnt_step_value),
    .cnt_count_to_value   (cnt_count_to_value),
    .cnt_count_hit        (cnt_count_hit)
  );

  // Behavioural stand-in for the attached counter.
  logic [W-1:0] cnt_q;
  assign cnt_count_hit = (cnt_q == cnt_count_to_value);
  always @(posedge clk) begin
    if (cnt_rst) cnt_q <= '0;
    else if (cnt_load) cnt_q <= cnt_load_value;
    else if (cnt_enb && !(cnt_one_shot && cnt_count_hit))
      cnt_q <= cnt_dir ? cnt_q - cnt_step_value : cnt_q + cnt_step_value;
  end

  // ---------------- clock/reset bookkeeping ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int              checks   = 0;
  int              failures = 0;
  logic [EW-1:0]   exp_q[$];
  int              m_ptr  = 0;
  int              m_free = 0;
  int              m_from = -10;
  int              m_to   = -10;
  int              m_d    = 0;
  logic [N-1:0]    last_ack = '0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endfunction

  function automatic logic [EW-1:0] mk_evt(input bit is_done, input int idx, input int c);
    logic [N-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return {is_done, oh, 32'(c)};
  endfunction

  // ---------------- monitor + reference model ----------------
  always @(negedge clk) begin : mon
    int c;
    int w;
    logic [EW-1:0] e;
    c = cyc;
    last_ack = ack;
    check("cnt_rst", 64'(cnt_rst), 64'(rst));
    check("cnt_const", {cnt_dir, cnt_one_shot, cnt_step_value, cnt_count_from_value, cnt_load_value},
          {1'b0, 1'b1, 8'd1, 8'd0, 8'd0});
    if (rst) begin
      check("rst_outputs", {ack, done, busy, cnt_load, cnt_enb}, 64'd0);
      exp_q.delete();
      m_ptr  = 0;
      m_free = c + 1;
      m_from = -10;
      m_to   = -10;
    end else begin
      check("busy", 64'(busy), 64'(c >= m_from && c <= m_to));
      check("cnt_load", 64'(cnt_load), 64'(c == m_from));
      check("cnt_enb", 64'(cnt_enb), 64'(c > m_from && c < m_to));
      if (c > m_from && c <= m_to) check("count_to", 64'(cnt_count_to_value), 64'(m_d));
      while (exp_q.size() > 0 && int'(exp_q[0][31:0]) < c) begin
        e = exp_q.pop_front();
        check("missed_event", 64'(c), 64'(e[31:0]));
      end
      if (ack != '0 || done != '0) begin
        check("ack_done_overlap", 64'(ack != '0 && done != '0), 64'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_output", {ack, done}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("event", {(done != '0), (ack | done), 32'(c)}, 64'(e));
        end
      end
      // A grant happens whenever the scheduler is free and someone is asking.
      if (c >= m_free && req != '0) begin
        w = -1;
        for (int k = 0; k < N; k++)
          if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        m_d = int'(delay[w*W +: W]);
        exp_q.push_back(mk_evt(1'b0, w, c + 1));
        exp_q.push_back(mk_evt(1'b1, w, c + 3 + m_d));
        m_from = c + 1;
        m_to   = c + 3 + m_d;
        m_free = c + 4 + m_d;
        m_ptr  = (w + 1) % N;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_delay(input int idx, input int d);
    delay[idx*W +: W] = W'(d);
  endtask

  task automatic issue(input int idx, input int d);
    set_delay(idx, d);
    req[idx] = 1'b1;
  endtask

  task automatic wait_ack(input int idx);
    int n;
    n = 0;
    step();
    while (!last_ack[idx] && n < 600) begin
      step();
      n++;
    end
    check("ack_timeout", 64'(last_ack[idx]), 64'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || cyc <= m_to + 1) && n < 2000) begin
      step();
      n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst   = 1'b1;
    req   = '0;
    delay = '0;
    repeat (3) step();
    rst = 1'b0;
    step();

    issue(0, 5);  wait_ack(0); req[0] = 1'b0; wait_idle();
    issue(2, 0);  wait_ack(2); req[2] = 1'b0; wait_idle();

    for (int i = 0; i < N; i++) set_delay(i, 2);
    req = '1;
    repeat (26) step();
    req = '0;
    wait_idle();

    issue(1, 10); wait_ack(1);
    set_delay(1, 3); req[1] = 1'b0;
    wait_idle();

    issue(2, 20); wait_ack(2); req[2] = 1'b0;
    repeat (5) step();
    rst = 1'b1; step(); rst = 1'b0;
    issue(0, 1); issue(3, 2);
    wait_ack(0); req[0] = 1'b0;
    wait_ack(3); req[3] = 1'b0;
    wait_idle();

    issue(3, 255); wait_ack(3); req[3] = 1'b0; wait_idle();

    repeat (1500) begin
      step();
      rst = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < N; i++) begin
        if (last_ack[i]) begin
          req[i] = 1'b0;
          set_delay(i, $urandom_range(0, 255));
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          issue(i, ($urandom_range(0, 19) == 0) ? 255 : $urandom_range(0, 9));
        end
      end
    end
    rst = 1'b0;
    req = '0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
